// File: rtl/ltssm_pkg.sv
// ltssm_pkg
//   Definitions shared by the transmit-side and receive-side LTSSM blocks:
//   substate codes, ordered-set symbol constants, the transmit FSM encoding,
//   and helpers that map a substate code to its ordered-set quota and set type.
package ltssm_pkg;

   // LTSSM substate codes (common encoding for TX and RX sides)
   localparam logic [3:0] SS_DETECT_QUIET    = 4'd0;
   localparam logic [3:0] SS_DETECT_ACTIVE   = 4'd1;
   localparam logic [3:0] SS_POLLING_ACTIVE  = 4'd2;
   localparam logic [3:0] SS_POLLING_CONFIG  = 4'd3;
   localparam logic [3:0] SS_CFG_LW_START    = 4'd4;
   localparam logic [3:0] SS_CFG_LW_ACCEPT   = 4'd5;
   localparam logic [3:0] SS_CFG_LN_WAIT     = 4'd6;
   localparam logic [3:0] SS_CFG_LN_ACCEPT   = 4'd7;
   localparam logic [3:0] SS_CFG_COMPLETE    = 4'd8;
   localparam logic [3:0] SS_CFG_IDLE        = 4'd9;
   localparam logic [3:0] SS_L0              = 4'd10;

   // Ordered-set symbols
   localparam logic [7:0] SYM_COM    = 8'hBC;
   localparam logic [7:0] SYM_PAD    = 8'hF7;
   localparam logic [7:0] SYM_TS1_ID = 8'h4A;
   localparam logic [7:0] SYM_TS2_ID = 8'h45;
   localparam logic [7:0] SYM_IDLE   = 8'h00;

   localparam int NUM_LANES = 16;
   localparam int SET_BITS  = 128;

   typedef enum logic [1:0] {
      SET_NONE = 2'd0,
      SET_TS1  = 2'd1,
      SET_TS2  = 2'd2,
      SET_IDLE = 2'd3
   } set_type_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_DONE = 2'd2
   } tx_state_t;

   // Number of ordered sets the substate must transmit before finishing.
   function automatic logic [10:0] target_count(input logic [3:0] ss);
      case (ss)
         SS_POLLING_ACTIVE: target_count = 11'd1024;
         SS_POLLING_CONFIG,
         SS_CFG_LW_START,
         SS_CFG_LW_ACCEPT,
         SS_CFG_LN_WAIT,
         SS_CFG_LN_ACCEPT,
         SS_CFG_COMPLETE,
         SS_CFG_IDLE:       target_count = 11'd16;
         default:           target_count = 11'd0;
      endcase
   endfunction

   function automatic set_type_t set_type_of(input logic [3:0] ss);
      case (ss)
         SS_POLLING_ACTIVE,
         SS_CFG_LW_START,
         SS_CFG_LW_ACCEPT,
         SS_CFG_LN_WAIT,
         SS_CFG_LN_ACCEPT:  set_type_of = SET_TS1;
         SS_POLLING_CONFIG,
         SS_CFG_COMPLETE:   set_type_of = SET_TS2;
         SS_CFG_IDLE:       set_type_of = SET_IDLE;
         default:           set_type_of = SET_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tx_ltssm_if.sv
// tx_ltssm_if
//   Ordered-set bus between the TX LTSSM (master) and the lane packer (slave).
//   Signals: orderedSets (16 lanes x 128 bits), laneMask (active lanes),
//   osValid (set offered), osReady (packer can take it).
//
//   Handshake: a set transfers on every rising clk edge where osValid and
//   osReady are both high. While osValid is high and osReady is low, the
//   master holds osValid, orderedSets and laneMask unchanged. osValid never
//   depends combinationally on osReady; one transfer per cycle is allowed.
interface tx_ltssm_if;
   logic [2047:0] orderedSets;
   logic [15:0]   laneMask;
   logic          osValid;
   logic          osReady;

   modport master (output orderedSets, output laneMask, output osValid, input osReady);
   modport slave  (input orderedSets, input laneMask, input osValid, output osReady);
endinterface

// File: rtl/ts_builder.sv
// ts_builder
//   Combinational builder of one lane's 16-symbol ordered set.
//   Ports:
//     i_setType    - TS1, TS2, Idle or none
//     i_laneEn     - lane is active; inactive lanes output all zeros
//     i_padLink    - drive PAD in the link-number symbol
//     i_padLane    - drive PAD in the lane-number symbol (else LANE index)
//     i_useUpCfg   - replace rate bit 6 with i_upCfg (TS2 only)
//     i_upCfg      - upconfigure capability bit
//     i_linkNumber - link number symbol value
//     i_rateId     - rate identifier symbol value
//     i_nFts       - N_FTS symbol value
//     o_set        - symbol k at bits [8k+7:8k]
module ts_builder
   import ltssm_pkg::*;
#(
   parameter int LANE = 0
)(
   input  set_type_t    i_setType,
   input  logic         i_laneEn,
   input  logic         i_padLink,
   input  logic         i_padLane,
   input  logic         i_useUpCfg,
   input  logic         i_upCfg,
   input  logic [7:0]   i_linkNumber,
   input  logic [7:0]   i_rateId,
   input  logic [7:0]   i_nFts,
   output logic [127:0] o_set
);

   logic [7:0] w_rate;
   logic [7:0] w_id;

   always_comb begin
      w_rate = i_rateId;
      if (i_useUpCfg && (i_setType == SET_TS2)) begin
         w_rate[6] = i_upCfg;
      end
      w_id = (i_setType == SET_TS1) ? SYM_TS1_ID : SYM_TS2_ID;
   end

   always_comb begin
      o_set = '0;
      // Idle sets are all-zero symbols, the same as an unused lane.
      if (i_laneEn && ((i_setType == SET_TS1) || (i_setType == SET_TS2))) begin
         o_set[7:0]   = SYM_COM;
         o_set[15:8]  = i_padLink ? SYM_PAD : i_linkNumber;
         o_set[23:16] = i_padLane ? SYM_PAD : 8'(LANE);
         o_set[31:24] = i_nFts;
         o_set[39:32] = w_rate;
         o_set[47:40] = 8'h00;
         for (int k = 6; k < 16; k++) begin
            o_set[k*8 +: 8] = w_id;
         end
      end
   end

endmodule

// File: rtl/tx_ltssm.sv
// tx_ltssm
//   Transmit-side training-sequence generator. On an accepted start it
//   builds the substate's ordered set for every active lane, offers it on the
//   bus until the substate's quota of sets has been accepted, then pulses
//   o_finish for one cycle.
//   Ports:
//     clk, reset               - clock, asynchronous active-high reset
//     i_start                  - request, accepted only in IDLE
//     i_stop                   - abort; overrides everything, no finish
//     i_substate               - LTSSM substate code
//     i_numberOfDetectedLanes  - active lanes, 1..16
//     i_linkNumber, i_rateId   - link number / rate id symbols
//     i_upConfigureCapability  - TS2 rate bit 6 in Config.Complete
//     bus                      - ordered-set bus (master side)
//     o_busy                   - FSM not idle
//     o_finish                 - quota reached (high during DONE)
//     o_txCount                - sets accepted for the current request
//     o_state                  - FSM state, for observation
module tx_ltssm
   import ltssm_pkg::*;
#(
   parameter bit         DEVICETYPE = 1'b0,
   parameter logic [7:0] NFTS       = 8'd255
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [3:0]  i_substate,
   input  logic [4:0]  i_numberOfDetectedLanes,
   input  logic [7:0]  i_linkNumber,
   input  logic [7:0]  i_rateId,
   input  logic        i_upConfigureCapability,
   tx_ltssm_if.master  bus,
   output logic        o_busy,
   output logic        o_finish,
   output logic [10:0] o_txCount,
   output tx_state_t   o_state
);

   tx_state_t     r_state;
   tx_state_t     w_next;
   logic [10:0]   r_txCount;
   logic [10:0]   r_target;
   logic          r_osValid;
   logic [2047:0] r_orderedSets;
   logic [15:0]   r_laneMask;

   logic [10:0]   w_target;
   logic [2047:0] w_sets;
   logic [15:0]   w_laneMask;
   set_type_t     w_setType;
   logic          w_padLink;
   logic          w_padLane;
   logic          w_useUpCfg;
   logic          w_startOk;
   logic          w_accept;
   logic          w_lastAccept;

   // Request decode from the live inputs; everything derived here is
   // captured into registers on the accepted start, so later input changes
   // never reach the running request.
   assign w_target   = target_count(i_substate);
   assign w_setType  = set_type_of(i_substate);
   assign w_padLink  = (i_substate == SS_POLLING_ACTIVE) ||
                       (i_substate == SS_POLLING_CONFIG) ||
                       ((i_substate == SS_CFG_LW_START) && (DEVICETYPE == 1'b0));
   assign w_padLane  = (i_substate >= SS_POLLING_ACTIVE) && (i_substate <= SS_CFG_LW_ACCEPT);
   assign w_useUpCfg = (i_substate == SS_CFG_COMPLETE);

   always_comb begin
      w_laneMask = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         // 6-bit compare so that lane count 16 enables lane 15
         w_laneMask[i] = (6'(i) < {1'b0, i_numberOfDetectedLanes});
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      ts_builder #(.LANE(g)) u_ts_builder (
         .i_setType    (w_setType),
         .i_laneEn     (w_laneMask[g]),
         .i_padLink    (w_padLink),
         .i_padLane    (w_padLane),
         .i_useUpCfg   (w_useUpCfg),
         .i_upCfg      (i_upConfigureCapability),
         .i_linkNumber (i_linkNumber),
         .i_rateId     (i_rateId),
         .i_nFts       (NFTS),
         .o_set        (w_sets[g*SET_BITS +: SET_BITS])
      );
   end

   // Next-state logic. i_stop is applied last so it beats a simultaneous
   // start or final accept; a stopped accept is not counted.
   always_comb begin
      w_next       = r_state;
      w_startOk    = 1'b0;
      w_accept     = r_osValid & bus.osReady;
      w_lastAccept = w_accept && ((r_txCount + 11'd1) == r_target);
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_startOk = 1'b1;
               w_next    = (w_target == 11'd0) ? ST_DONE : ST_SEND;
            end
         end
         ST_SEND: begin
            if (w_lastAccept) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
      if (i_stop) begin
         w_next    = ST_IDLE;
         w_startOk = 1'b0;
         w_accept  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_osValid     <= 1'b0;
         r_txCount     <= '0;
         r_target      <= '0;
         r_orderedSets <= '0;
         r_laneMask    <= '0;
      end else begin
         // The set content is constant for a request, so holding it across
         // stalls is just not reloading it.
         r_osValid <= (w_next == ST_SEND);
         if (w_startOk) begin
            r_txCount     <= '0;
            r_target      <= w_target;
            r_orderedSets <= w_sets;
            r_laneMask    <= w_laneMask;
         end else if (w_accept) begin
            r_txCount <= r_txCount + 11'd1;
         end
      end
   end

   assign bus.orderedSets = r_orderedSets;
   assign bus.laneMask    = r_laneMask;
   assign bus.osValid     = r_osValid;
   assign o_busy          = (r_state != ST_IDLE);
   assign o_finish        = (r_state == ST_DONE);
   assign o_txCount       = r_txCount;
   assign o_state         = r_state;

endmodule

// File: tb/tb_tx_ltssm.sv
// tb_tx_ltssm
//   Directed-plus-random bench for tx_ltssm. Expected ordered sets, lane
//   masks and quotas come from a symbol-level model of the training rules.
module tb_tx_ltssm;
   import ltssm_pkg::*;

   localparam int         DEVTYPE = 1;
   localparam logic [7:0] NFTS_V  = 8'd255;

   logic        clk;
   logic        reset;
   logic        i_start;
   logic        i_stop;
   logic [3:0]  i_substate;
   logic [4:0]  i_numberOfDetectedLanes;
   logic [7:0]  i_linkNumber;
   logic [7:0]  i_rateId;
   logic        i_upConfigureCapability;
   logic        o_busy;
   logic        o_finish;
   logic [10:0] o_txCount;
   tx_state_t   o_state;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [2047:0] first_sets;
   int            quota [16] = '{0, 0, 1024, 16, 16, 16, 16, 16, 16, 16, 0, 0, 0, 0, 0, 0};

   tx_ltssm_if bus ();

   tx_ltssm #(.DEVICETYPE(1'b1), .NFTS(NFTS_V)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .i_start                 (i_start),
      .i_stop                  (i_stop),
      .i_substate              (i_substate),
      .i_numberOfDetectedLanes (i_numberOfDetectedLanes),
      .i_linkNumber            (i_linkNumber),
      .i_rateId                (i_rateId),
      .i_upConfigureCapability (i_upConfigureCapability),
      .bus                     (bus),
      .o_busy                  (o_busy),
      .o_finish                (o_finish),
      .o_txCount               (o_txCount),
      .o_state                 (o_state)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [127:0] model_lane(input int ss, input int lanes, input logic [7:0] link,
                                               input logic [7:0] rate, input logic upcfg, input int lane);
      logic [7:0]   s [16];
      logic [127:0] v;
      bit           ts1;
      bit           ts2;
      v   = '0;
      ts1 = (ss == 2) || (ss >= 4 && ss <= 7);
      ts2 = (ss == 3) || (ss == 8);
      if (lane >= lanes || !(ts1 || ts2)) return v;
      s[0] = 8'hBC;
      s[1] = (ss == 2 || ss == 3 || (ss == 4 && DEVTYPE == 0)) ? 8'hF7 : link;
      s[2] = (ss <= 5) ? 8'hF7 : 8'(lane);
      s[3] = NFTS_V;
      s[4] = rate;
      if (ss == 8) s[4][6] = upcfg;
      s[5] = 8'h00;
      for (int k = 6; k < 16; k++) s[k] = ts1 ? 8'h4A : 8'h45;
      for (int k = 0; k < 16; k++) v[k*8 +: 8] = s[k];
      return v;
   endfunction

   function automatic logic [2047:0] model_sets(input int ss, input int lanes, input logic [7:0] link,
                                                input logic [7:0] rate, input logic upcfg);
      logic [2047:0] v;
      v = '0;
      for (int l = 0; l < 16; l++) v[l*128 +: 128] = model_lane(ss, lanes, link, rate, upcfg, l);
      return v;
   endfunction

   function automatic logic [7:0] sym(input int l, input int k);
      return first_sets[l*128 + k*8 +: 8];
   endfunction

   // ---------------- checkers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_sets(input string tag, input logic [2047:0] exp);
      n_tests++;
      assert (bus.orderedSets === exp) else begin
         n_fail++;
         for (int l = 0; l < 16; l++) begin
            if (bus.orderedSets[l*128 +: 128] !== exp[l*128 +: 128]) begin
               $error("FAIL %s lane %0d observed=%h expected=%h", tag, l,
                      bus.orderedSets[l*128 +: 128], exp[l*128 +: 128]);
               break;
            end
         end
      end
   endtask

   // ---------------- driver ----------------
   // ready_mode: 0 always ready, 1 toggling, 2 random.
   // stop_at: accept count at which stop is raised (-1 = never).
   task automatic run_req(input int ss, input int lanes, input logic [7:0] link, input logic [7:0] rate,
                          input logic upcfg, input int ready_mode, input int stop_at,
                          input bit stop_ready, input bit busy_start);
      int            target;
      int            accepts;
      int            cycles;
      bit            rdy;
      bit            probed;
      string         t;
      logic [2047:0] exp_sets;
      logic [15:0]   exp_mask;
      target   = quota[ss];
      exp_sets = model_sets(ss, lanes, link, rate, upcfg);
      exp_mask = 16'((32'd1 << lanes) - 32'd1);
      t        = $sformatf("ss%0d", ss);

      bus.osReady             = 1'b0;
      i_start                 = 1'b1;
      i_substate              = 4'(ss);
      i_numberOfDetectedLanes = 5'(lanes);
      i_linkNumber            = link;
      i_rateId                = rate;
      i_upConfigureCapability = upcfg;
      @(negedge clk);
      i_start = 1'b0;
      // new input values must not disturb the running request
      i_substate              = 4'($urandom_range(0, 15));
      i_numberOfDetectedLanes = 5'($urandom_range(1, 16));
      i_linkNumber            = 8'($urandom);
      i_rateId                = 8'($urandom);
      i_upConfigureCapability = 1'($urandom);

      if (target == 0) begin
         chk({t, "_nt_valid"}, bus.osValid, 0);
      end else begin
         chk({t, "_first_valid"}, bus.osValid, 1);
         chk({t, "_first_cnt"}, o_txCount, 0);
         chk({t, "_mask"}, bus.laneMask, exp_mask);
         chk({t, "_busy"}, o_busy, 1);
         chk_sets({t, "_first_sets"}, exp_sets);
         first_sets = bus.orderedSets;
         accepts = 0;
         cycles  = 0;
         probed  = 1'b0;
         while (accepts < target) begin
            if (cycles >= 4000) begin
               n_tests++;
               n_fail++;
               $error("FAIL %s_timeout observed=%0d accepts expected=%0d", t, accepts, target);
               break;
            end
            i_start = 1'b0;
            if (busy_start && !probed && accepts == 3) begin
               i_start    = 1'b1;
               i_substate = 4'd0;
               probed     = 1'b1;
            end
            if (accepts == stop_at) begin
               bus.osReady = stop_ready;
               i_stop      = 1'b1;
               @(negedge clk);
               i_stop      = 1'b0;
               i_start     = 1'b0;
               bus.osReady = 1'b0;
               chk({t, "_stop_finish"}, o_finish, 0);
               chk({t, "_stop_busy"}, o_busy, 0);
               chk({t, "_stop_valid"}, bus.osValid, 0);
               if (!stop_ready) chk({t, "_stop_cnt"}, o_txCount, stop_at);
               @(negedge clk);
               chk({t, "_stop_finish2"}, o_finish, 0);
               return;
            end
            case (ready_mode)
               0:       rdy = 1'b1;
               1:       rdy = ((cycles % 2) == 0);
               default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.osReady = rdy;
            @(negedge clk);
            cycles++;
            if (rdy) accepts++;
            chk({t, "_cnt"}, o_txCount, accepts);
            if (accepts < target) begin
               chk({t, "_valid"}, bus.osValid, 1);
               chk({t, "_no_early_finish"}, o_finish, 0);
               chk_sets({t, "_stable_sets"}, exp_sets);
            end
         end
         bus.osReady = 1'b0;
         i_start     = 1'b0;
      end

      chk({t, "_finish"}, o_finish, 1);
      chk({t, "_fin_valid"}, bus.osValid, 0);
      chk({t, "_fin_busy"}, o_busy, 1);
      chk({t, "_fin_cnt"}, o_txCount, target);
      // a start during the DONE cycle is ignored
      i_start    = 1'b1;
      i_substate = 4'd0;
      @(negedge clk);
      i_start = 1'b0;
      chk({t, "_after_finish"}, o_finish, 0);
      chk({t, "_after_busy"}, o_busy, 0);
      chk({t, "_after_valid"}, bus.osValid, 0);
      chk({t, "_after_cnt"}, o_txCount, target);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int ss_r;
      reset                   = 1'b1;
      i_start                 = 1'b0;
      i_stop                  = 1'b0;
      i_substate              = '0;
      i_numberOfDetectedLanes = 5'd1;
      i_linkNumber            = '0;
      i_rateId                = '0;
      i_upConfigureCapability = 1'b0;
      bus.osReady             = 1'b0;
      first_sets              = '0;
      repeat (3) @(negedge clk);

      chk("rst_valid", bus.osValid, 0);
      chk_sets("rst_sets", '0);
      chk("rst_mask", bus.laneMask, 0);
      chk("rst_finish", o_finish, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_cnt", o_txCount, 0);
      chk("rst_state", o_state, ST_IDLE);
      reset = 1'b0;
      @(negedge clk);

      // Polling.Active, 4 lanes, always ready
      run_req(2, 4, 8'($urandom), 8'($urandom), 1'b0, 0, -1, 1'b0, 1'b0);
      chk("pa_l2_sym1", sym(2, 1), 8'hF7);
      chk("pa_l2_sym2", sym(2, 2), 8'hF7);
      for (int k = 6; k < 16; k++) chk($sformatf("pa_l2_sym%0d", k), sym(2, k), 8'h4A);
      chk("pa_l4_off", first_sets[4*128 +: 128], 0);

      // Config.LaneNum.Wait, 16 lanes, link 5, toggling ready
      run_req(6, 16, 8'h05, 8'($urandom), 1'b0, 1, -1, 1'b0, 1'b0);
      chk("lnw_l9_sym2", sym(9, 2), 8'h09);
      chk("lnw_l9_sym1", sym(9, 1), 8'h05);

      // Config.Complete with upconfigure
      run_req(8, $urandom_range(1, 16), 8'($urandom), 8'h02, 1'b1, 2, -1, 1'b0, 1'b0);
      chk("cc_sym4", sym(0, 4), 8'h42);
      for (int k = 6; k < 16; k++) chk($sformatf("cc_sym%0d", k), sym(0, k), 8'h45);

      // Detect.Quiet: no transmit, finish next cycle
      run_req(0, 4, 8'h00, 8'h00, 1'b0, 0, -1, 1'b0, 1'b0);

      // Config.Idle stopped at 7 with a start issued while busy
      run_req(9, $urandom_range(1, 16), 8'($urandom), 8'($urandom), 1'b0, 0, 7, 1'b0, 1'b1);

      // stop coinciding with the final accept
      run_req(5, $urandom_range(1, 16), 8'($urandom), 8'($urandom), 1'b0, 0, 15, 1'b1, 1'b0);

      // stop and start together in IDLE
      i_start    = 1'b1;
      i_stop     = 1'b1;
      i_substate = 4'd9;
      @(negedge clk);
      i_start = 1'b0;
      i_stop  = 1'b0;
      chk("stopstart_busy", o_busy, 0);
      chk("stopstart_valid", bus.osValid, 0);
      chk("stopstart_finish", o_finish, 0);

      // asynchronous reset in the middle of Polling.Active
      i_start                 = 1'b1;
      i_substate              = 4'd2;
      i_numberOfDetectedLanes = 5'd8;
      @(negedge clk);
      i_start     = 1'b0;
      bus.osReady = 1'b1;
      repeat (40) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_valid", bus.osValid, 0);
      chk_sets("arst_sets", '0);
      chk("arst_mask", bus.laneMask, 0);
      chk("arst_finish", o_finish, 0);
      chk("arst_busy", o_busy, 0);
      chk("arst_cnt", o_txCount, 0);
      @(negedge clk);
      reset       = 1'b0;
      bus.osReady = 1'b0;
      @(negedge clk);
      run_req(2, $urandom_range(1, 16), 8'($urandom), 8'($urandom), 1'b0, 0, -1, 1'b0, 1'b0);

      // random requests (Polling.Active left out to bound run time)
      repeat (8) begin
         ss_r = $urandom_range(3, 15);
         run_req(ss_r, $urandom_range(1, 16), 8'($urandom), 8'($urandom), 1'($urandom),
                 $urandom_range(0, 2), -1, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
